// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: scheduler state encoding and default constants for the frequency scanner
package freq_meas_pkg;
    localparam int CLK_HZ = 50_000_000;
    localparam int FREQ_W = 20;
    typedef enum logic [2:0] {IDLE, CLEAR, MEASURE, CAPTURE, OUTPUT} state_t;
endpackage

// File: rtl/input_sync.sv
// input_sync: two-flop synchroniser for one asynchronous input pin
module input_sync (
    input  logic clock,
    input  logic clear_all_n,
    input  logic d,
    output logic q
);
    logic meta;
    // shift the pin through two flops to settle metastability
    always_ff @(posedge clock or negedge clear_all_n)
        if (!clear_all_n) {q, meta} <= 2'b00;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/freq_scan_controller.sv
// freq_scan_controller: round-robin scheduler sharing one frequency datapath among NUM_CH pins
module freq_scan_controller #(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 2,
    parameter int FREQ_W         = freq_meas_pkg::FREQ_W,
    parameter int EDGES_PER_MEAS = 3,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TMR_W          = 26
) (
    input  logic              clock,
    input  logic              clear_all_n,
    input  logic              scan_en,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] sig_in,
    input  logic [FREQ_W-1:0] freq_value,
    output logic              meas_clear,
    output logic              meas_edge,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CH_W-1:0]   res_chan,
    output logic [FREQ_W-1:0] res_freq,
    output logic              res_timeout,
    output logic              busy
);
    import freq_meas_pkg::*;
    localparam int EC_W = $clog2(EDGES_PER_MEAS + 1);
    state_t            state;
    logic [NUM_CH-1:0] sync;
    logic [CH_W-1:0]   ptr, chan, chan_inc, start, pick;
    logic              prev, edge_q, last_edge, tmo, go;
    logic [EC_W-1:0]   edge_cnt;
    logic [TMR_W-1:0]  timer;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        input_sync u_sync (.clock(clock), .clear_all_n(clear_all_n), .d(sig_in[g]), .q(sync[g]));
    end

    assign chan_inc   = (int'(chan) == NUM_CH - 1) ? '0 : chan + 1'b1;
    assign start      = (state == OUTPUT) ? chan_inc : ptr;
    assign go         = scan_en && |ch_mask;
    assign meas_edge  = edge_q && state == MEASURE;
    assign last_edge  = meas_edge && edge_cnt == EC_W'(EDGES_PER_MEAS - 1);
    assign tmo        = timer == TMR_W'(TIMEOUT_CYCLES - 1);
    assign meas_clear = state == IDLE || state == CLEAR;
    assign busy       = state != IDLE;

    // first masked channel at or after start, wrapping; scanning downward lets the nearest win
    always_comb begin
        pick = start;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (ch_mask[(int'(start) + i) % NUM_CH]) pick = CH_W'((int'(start) + i) % NUM_CH);
    end

    // edge detect on the selected channel; prev follows the new channel during CLEAR so a switch never fakes an edge
    always_ff @(posedge clock or negedge clear_all_n)
        if (!clear_all_n) begin
            prev   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            prev   <= sync[chan];
            edge_q <= state == MEASURE && sync[chan] && !prev;
        end

    // scheduler: select, clear datapath, count edges against the timeout, capture, hand off
    always_ff @(posedge clock or negedge clear_all_n)
        if (!clear_all_n) begin
            state       <= IDLE;
            ptr         <= '0;
            chan        <= '0;
            edge_cnt    <= '0;
            timer       <= '0;
            res_valid   <= 1'b0;
            res_chan    <= '0;
            res_freq    <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    chan  <= pick;
                    state <= CLEAR;
                end
                CLEAR: begin
                    edge_cnt <= '0;
                    timer    <= '0;
                    state    <= MEASURE;
                end
                MEASURE: begin
                    timer <= timer + 1'b1;
                    if (meas_edge) edge_cnt <= edge_cnt + 1'b1;
                    if (last_edge) state <= CAPTURE;
                    else if (tmo) begin
                        res_freq    <= '0;
                        res_timeout <= 1'b1;
                        res_chan    <= chan;
                        res_valid   <= 1'b1;
                        state       <= OUTPUT;
                    end
                end
                CAPTURE: begin
                    res_freq    <= freq_value;
                    res_timeout <= 1'b0;
                    res_chan    <= chan;
                    res_valid   <= 1'b1;
                    state       <= OUTPUT;
                end
                OUTPUT: if (res_ready) begin
                    res_valid <= 1'b0;
                    ptr       <= chan_inc;
                    chan      <= pick;
                    state     <= go ? CLEAR : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_freq_scan_controller.sv
// tb_freq_scan_controller: randomized directed bench with a behavioural scheduling and frequency model
module tb_freq_scan_controller;
    import freq_meas_pkg::*;
    localparam int TMO = 1000;
    logic        clock = 1'b0, clear_all_n = 1'b0, scan_en = 1'b0, res_ready = 1'b0;
    logic [3:0]  ch_mask = 4'b0, sig_in = 4'b0;
    logic [19:0] freq_value;
    logic        meas_clear, meas_edge, res_valid, res_timeout, busy;
    logic [1:0]  res_chan;
    logic [19:0] res_freq;
    int tests = 0, fails = 0;
    int per[4];
    int gen_cnt[4];
    int model_ptr = 0;
    int cyc = 0, last_edge_cyc = 0, edge_n = 0, meas_n = 0;
    int dp_cnt;

    freq_scan_controller #(
        .NUM_CH(4), .CH_W(2), .FREQ_W(20), .EDGES_PER_MEAS(3), .TIMEOUT_CYCLES(TMO), .TMR_W(26)
    ) dut (
        .clock(clock), .clear_all_n(clear_all_n), .scan_en(scan_en), .ch_mask(ch_mask),
        .sig_in(sig_in), .freq_value(freq_value), .meas_clear(meas_clear), .meas_edge(meas_edge),
        .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan), .res_freq(res_freq),
        .res_timeout(res_timeout), .busy(busy)
    );

    initial forever #10 clock = ~clock;

    // datapath stand-in: frequency from the spacing of the two most recent edges
    always @(posedge clock)
        if (meas_clear) begin
            dp_cnt     <= 0;
            freq_value <= '0;
        end else begin
            dp_cnt <= meas_edge ? 0 : dp_cnt + 1;
            if (meas_edge) freq_value <= 20'(CLK_HZ / (dp_cnt + 1));
        end

    // square-wave sources; a zero period holds the pin low
    initial forever begin
        @(negedge clock);
        for (int c = 0; c < 4; c++)
            if (per[c] != 0) begin
                gen_cnt[c]++;
                if (gen_cnt[c] >= per[c] / 2) begin
                    gen_cnt[c] = 0;
                    sig_in[c] = ~sig_in[c];
                end
            end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
        if (meas_clear) begin
            edge_n = 0;
            meas_n = 0;
        end else if (busy && !res_valid) meas_n++;
        if (meas_edge) begin
            edge_n++;
            last_edge_cyc = cyc;
        end
    endtask

    function automatic int exp_next(input int p, input logic [3:0] m);
        for (int k = 0; k < 4; k++)
            if (m[(p + k) % 4]) return (p + k) % 4;
        return p;
    endfunction

    task automatic run_phase(input logic [3:0] mask, input int nres, input int stall, input bit always_rdy);
        int got = 0;
        int budget = nres * 1500 + 100 + stall;
        int stall_left = stall;
        int exp_ch;
        bit was_valid = 1'b0;
        logic [1:0] h_ch;
        logic [19:0] h_f;
        logic h_t;
        ch_mask = mask;
        scan_en = 1'b1;
        exp_ch = exp_next(model_ptr, mask);
        while (got < nres && budget > 0) begin
            tick();
            budget--;
            if (got == nres - 1 && busy && !meas_clear) scan_en = 1'b0;
            if (res_valid) begin
                if (!was_valid) begin
                    chk("edge_count", edge_n, per[exp_ch] == 0 ? 0 : 3);
                    if (per[exp_ch] == 0) chk("timeout_cycles", meas_n, TMO);
                    else chk("result_latency", cyc - last_edge_cyc, 2);
                    h_ch = res_chan;
                    h_f = res_freq;
                    h_t = res_timeout;
                end else begin
                    chk("hold_chan", res_chan, h_ch);
                    chk("hold_freq", res_freq, h_f);
                    chk("hold_timeout", res_timeout, h_t);
                    chk("hold_meas_clear", meas_clear, 0);
                    chk("hold_busy", busy, 1);
                end
                if (stall_left > 0) stall_left--;
                res_ready = always_rdy || (stall_left == 0 && $urandom_range(0, 3) != 0);
                was_valid = 1'b1;
                if (res_ready) begin
                    chk("res_chan", res_chan, exp_ch);
                    chk("res_freq", res_freq, per[exp_ch] == 0 ? 0 : CLK_HZ / per[exp_ch]);
                    chk("res_timeout", res_timeout, per[exp_ch] == 0);
                    model_ptr = (exp_ch + 1) % 4;
                    exp_ch = exp_next(model_ptr, mask);
                    got++;
                    was_valid = 1'b0;
                    tick();
                    budget--;
                    res_ready = always_rdy;
                    chk("after_accept_busy", busy, scan_en);
                    chk("after_accept_meas_clear", meas_clear, 1);
                    chk("after_accept_valid", res_valid, 0);
                end
            end else begin
                res_ready = always_rdy;
                was_valid = 1'b0;
            end
        end
        chk("phase_results", got, nres);
        scan_en = 1'b0;
        res_ready = 1'b0;
    endtask

    initial begin
        int wait_n;
        per[0] = 100;
        per[1] = 2 * $urandom_range(25, 100);
        per[2] = 0;
        per[3] = 2 * $urandom_range(25, 100);
        repeat (3) tick();
        chk("rst_meas_clear", meas_clear, 1);
        chk("rst_meas_edge", meas_edge, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_chan", res_chan, 0);
        chk("rst_freq", res_freq, 0);
        chk("rst_timeout", res_timeout, 0);
        chk("rst_busy", busy, 0);
        clear_all_n = 1'b1;
        tick();
        run_phase(4'b0001, 2, 0, 1'b0);
        run_phase(4'b0100, 1, 0, 1'b0);
        run_phase(4'b1010, 4, 0, 1'b1);
        run_phase(4'b1111, 3, 50, 1'b0);
        scan_en = 1'b1;
        ch_mask = 4'b0000;
        repeat (30) begin
            tick();
            chk("nomask_busy", busy, 0);
            chk("nomask_meas_clear", meas_clear, 1);
            chk("nomask_valid", res_valid, 0);
        end
        scan_en = 1'b0;
        ch_mask = 4'b1111;
        repeat (30) begin
            tick();
            chk("noscan_busy", busy, 0);
            chk("noscan_meas_clear", meas_clear, 1);
            chk("noscan_valid", res_valid, 0);
        end
        repeat (4) run_phase(4'($urandom_range(1, 15)), $urandom_range(2, 5), 0, 1'b0);
        ch_mask = 4'b0010;
        scan_en = 1'b1;
        wait_n = 0;
        while (!(busy && !meas_clear) && wait_n < 100) begin
            tick();
            wait_n++;
        end
        chk("reach_measure", wait_n < 100, 1);
        repeat (20) tick();
        chk("pre_reset_busy", busy, 1);
        #3 clear_all_n = 1'b0;
        scan_en = 1'b0;
        #1;
        chk("async_rst_meas_clear", meas_clear, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", res_valid, 0);
        chk("async_rst_edge", meas_edge, 0);
        chk("async_rst_chan", res_chan, 0);
        tick();
        clear_all_n = 1'b1;
        model_ptr = 0;
        run_phase(4'b1011, 2, 0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
